// File: rtl/morse_seq_ctrl_if.sv
// Handshake and LED-side signal bundle for morse_seq_ctrl.
// The message source uses the master modport; the sequencer uses slave.
interface morse_seq_ctrl_if;
    logic       in_valid;
    logic [7:0] in_char;
    logic       in_ready;
    logic       abort;
    logic [7:0] led;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output in_valid,
        output in_char,
        output abort,
        input  in_ready,
        input  led,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  in_valid,
        input  in_char,
        input  abort,
        output in_ready,
        output led,
        output busy,
        output done,
        output err
    );
endinterface

// File: rtl/morse_seq_ctrl.sv
// Character-level Morse sequencer driving the 8-bit LED bank.
// Accepts one ASCII character per handshake, looks up its Morse pattern and
// plays marks/gaps with ITU unit timing (dot 1, dash 3, element gap 1,
// character gap 3, word gap 7 = character gap 3 + 4 extra units).
// Optional feature macro: MORSE_DIGITS_EN -- when defined, '0'..'9' map to
// their 5-element patterns; otherwise digits take the error path and the
// pattern storage shrinks to 4 elements.
module morse_seq_ctrl #(
    parameter int unsigned UNIT_CYCLES = 6_250_000,
    parameter logic [7:0]  LED_ON      = 8'hFF
) (
    input  logic            clk,
    input  logic            rst,
    morse_seq_ctrl_if.slave bus
);

`ifdef MORSE_DIGITS_EN
    localparam int unsigned MAX_LEN = 5;
    localparam int unsigned IW      = 3;
`else
    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned IW      = 2;
`endif

    // Cycle counter spans the longest state (word gap, 4 units) without wrapping.
    localparam int unsigned CW = $clog2(4 * UNIT_CYCLES);

    localparam logic [CW-1:0] LAST_1U = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] LAST_3U = CW'(3 * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] LAST_4U = CW'(4 * UNIT_CYCLES - 1);
    // One cycle before the end of a gap: this is where done gets registered,
    // so it appears on the gap's final cycle.
    localparam logic [CW-1:0] PRE_3U  = CW'(3 * UNIT_CYCLES - 2);
    localparam logic [CW-1:0] PRE_4U  = CW'(4 * UNIT_CYCLES - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARK,
        S_EGAP,
        S_CHAR_GAP,
        S_WORD_GAP
    } state_t;

    typedef enum logic [1:0] {
        K_BAD,
        K_LETTER,
        K_SPACE
    } kind_t;

    // len = element count, pat = elements right-aligned, MSB-first, 1 = dash.
    typedef struct packed {
        kind_t              kind;
        logic [2:0]         len;
        logic [MAX_LEN-1:0] pat;
    } code_t;

    function automatic code_t mk(input logic [2:0] len, input logic [4:0] pat);
        code_t c;
        c.kind = K_LETTER;
        c.len  = len;
        c.pat  = MAX_LEN'(pat);
        return c;
    endfunction

    function automatic code_t lookup(input logic [7:0] ch);
        logic [7:0] uc;
        code_t      c;
        // NOTE: every output of a combinational block gets a default first so no latch is inferred on unmatched codes.
        c  = '{kind: K_BAD, len: 3'd0, pat: '0};
        uc = (ch >= 8'h61 && ch <= 8'h7A) ? ch - 8'h20 : ch;
        case (uc)
            8'h20: c.kind = K_SPACE;
            8'h41: c = mk(3'd2, 5'b00001); // A .-
            8'h42: c = mk(3'd4, 5'b01000); // B -...
            8'h43: c = mk(3'd4, 5'b01010); // C -.-.
            8'h44: c = mk(3'd3, 5'b00100); // D -..
            8'h45: c = mk(3'd1, 5'b00000); // E .
            8'h46: c = mk(3'd4, 5'b00010); // F ..-.
            8'h47: c = mk(3'd3, 5'b00110); // G --.
            8'h48: c = mk(3'd4, 5'b00000); // H ....
            8'h49: c = mk(3'd2, 5'b00000); // I ..
            8'h4A: c = mk(3'd4, 5'b00111); // J .---
            8'h4B: c = mk(3'd3, 5'b00101); // K -.-
            8'h4C: c = mk(3'd4, 5'b00100); // L .-..
            8'h4D: c = mk(3'd2, 5'b00011); // M --
            8'h4E: c = mk(3'd2, 5'b00010); // N -.
            8'h4F: c = mk(3'd3, 5'b00111); // O ---
            8'h50: c = mk(3'd4, 5'b00110); // P .--.
            8'h51: c = mk(3'd4, 5'b01101); // Q --.-
            8'h52: c = mk(3'd3, 5'b00010); // R .-.
            8'h53: c = mk(3'd3, 5'b00000); // S ...
            8'h54: c = mk(3'd1, 5'b00001); // T -
            8'h55: c = mk(3'd3, 5'b00001); // U ..-
            8'h56: c = mk(3'd4, 5'b00001); // V ...-
            8'h57: c = mk(3'd3, 5'b00011); // W .--
            8'h58: c = mk(3'd4, 5'b01001); // X -..-
            8'h59: c = mk(3'd4, 5'b01011); // Y -.--
            8'h5A: c = mk(3'd4, 5'b01100); // Z --..
`ifdef MORSE_DIGITS_EN
            8'h30: c = mk(3'd5, 5'b11111); // 0 -----
            8'h31: c = mk(3'd5, 5'b01111); // 1 .----
            8'h32: c = mk(3'd5, 5'b00111); // 2 ..---
            8'h33: c = mk(3'd5, 5'b00011); // 3 ...--
            8'h34: c = mk(3'd5, 5'b00001); // 4 ....-
            8'h35: c = mk(3'd5, 5'b00000); // 5 .....
            8'h36: c = mk(3'd5, 5'b10000); // 6 -....
            8'h37: c = mk(3'd5, 5'b11000); // 7 --...
            8'h38: c = mk(3'd5, 5'b11100); // 8 ---..
            8'h39: c = mk(3'd5, 5'b11110); // 9 ----.
`endif
            default: c = '{kind: K_BAD, len: 3'd0, pat: '0};
        endcase
        return c;
    endfunction

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [IW-1:0]      idx_q;
    logic [IW-1:0]      last_idx_q;
    logic [MAX_LEN-1:0] elem_q;    // remaining elements, current one at the MSB
    logic [7:0]         led_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    code_t              in_code;
    logic [MAX_LEN-1:0] in_aligned;
    logic               accept;
    logic [CW-1:0]      mark_last;

    assign in_code    = lookup(bus.in_char);
    // Left-align the pattern so the first element sits at the MSB.
    assign in_aligned = in_code.pat << (3'(MAX_LEN) - in_code.len);
    assign accept     = bus.in_valid && ready_q;
    assign mark_last  = elem_q[MAX_LEN-1] ? LAST_3U : LAST_1U;

    // Sequencer FSM: state, counters and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            last_idx_q <= '0;
            elem_q     <= '0;
            led_q      <= 8'h00;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        ready_q <= 1'b0;
                        cnt_q   <= '0;
                        case (in_code.kind)
                            K_LETTER: begin
                                state_q    <= S_MARK;
                                idx_q      <= '0;
                                last_idx_q <= IW'(in_code.len - 3'd1);
                                elem_q     <= in_aligned;
                                led_q      <= LED_ON;
                                busy_q     <= 1'b1;
                            end
                            K_SPACE: begin
                                state_q <= S_WORD_GAP;
                                busy_q  <= 1'b1;
                            end
                            default: begin
                                err_q <= 1'b1;
                            end
                        endcase
                    end
                end

                S_MARK: begin
                    if (bus.abort) begin
                        state_q    <= S_IDLE;
                        cnt_q      <= '0;
                        idx_q      <= '0;
                        last_idx_q <= '0;
                        elem_q     <= '0;
                        led_q      <= 8'h00;
                        busy_q     <= 1'b0;
                        ready_q    <= 1'b1;
                    end else if (cnt_q == mark_last) begin
                        cnt_q  <= '0;
                        led_q  <= 8'h00;
                        elem_q <= elem_q << 1;
                        idx_q  <= idx_q + 1'b1;
                        state_q <= (idx_q == last_idx_q) ? S_CHAR_GAP : S_EGAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_EGAP: begin
                    if (bus.abort) begin
                        state_q    <= S_IDLE;
                        cnt_q      <= '0;
                        idx_q      <= '0;
                        last_idx_q <= '0;
                        elem_q     <= '0;
                        led_q      <= 8'h00;
                        busy_q     <= 1'b0;
                        ready_q    <= 1'b1;
                    end else if (cnt_q == LAST_1U) begin
                        cnt_q   <= '0;
                        led_q   <= LED_ON;
                        state_q <= S_MARK;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_CHAR_GAP: begin
                    if (bus.abort) begin
                        state_q    <= S_IDLE;
                        cnt_q      <= '0;
                        idx_q      <= '0;
                        last_idx_q <= '0;
                        elem_q     <= '0;
                        led_q      <= 8'h00;
                        busy_q     <= 1'b0;
                        ready_q    <= 1'b1;
                    end else if (cnt_q == LAST_3U) begin
                        state_q    <= S_IDLE;
                        cnt_q      <= '0;
                        idx_q      <= '0;
                        last_idx_q <= '0;
                        busy_q     <= 1'b0;
                        ready_q    <= 1'b1;
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                        done_q <= (cnt_q == PRE_3U);
                    end
                end

                S_WORD_GAP: begin
                    if (bus.abort) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        led_q   <= 8'h00;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else if (cnt_q == LAST_4U) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                        done_q <= (cnt_q == PRE_4U);
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    led_q   <= 8'h00;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready = ready_q;
    assign bus.led      = led_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_morse_seq_ctrl.sv
// Self-checking bench for morse_seq_ctrl with UNIT_CYCLES = 4.
// Cycle 0 is the cycle whose closing edge accepts a character; outputs are
// sampled on the falling edge of each cycle.
module tb_morse_seq_ctrl;
    localparam int UNIT = 4;

    typedef struct packed {
        logic [7:0] led;
        logic       busy;
        logic       done;
        logic       ready;
        logic       err;
    } out_t;

    typedef struct {
        logic [7:0] ch;
        int         cyc;
        out_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    morse_seq_ctrl_if bus();

    morse_seq_ctrl #(
        .UNIT_CYCLES (UNIT),
        .LED_ON      (8'hFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    out_t log_q [0:63];
    vec_t vecs [$];

    function automatic out_t sample();
        out_t s;
        s.led   = bus.led;
        s.busy  = bus.busy;
        s.done  = bus.done;
        s.ready = bus.in_ready;
        s.err   = bus.err;
        return s;
    endfunction

    function automatic out_t o(input logic [7:0] led, input logic busy,
                               input logic done, input logic ready, input logic err);
        out_t s;
        s.led   = led;
        s.busy  = busy;
        s.done  = done;
        s.ready = ready;
        s.err   = err;
        return s;
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got led=%h busy=%b done=%b ready=%b err=%b, expected led=%h busy=%b done=%b ready=%b err=%b",
                     name, act.led, act.busy, act.done, act.ready, act.err,
                     exp.led, exp.busy, exp.done, exp.ready, exp.err);
        end
    endtask

    task automatic add(input logic [7:0] ch, input int cyc, input logic [7:0] led,
                       input logic busy, input logic done, input logic ready, input logic err);
        vec_t v;
        v.ch  = ch;
        v.cyc = cyc;
        v.exp = o(led, busy, done, ready, err);
        vecs.push_back(v);
    endtask

    // Called on a falling edge; returns on a falling edge with in_ready high.
    task automatic wait_ready();
        for (int i = 0; i < 200; i++) begin
            if (bus.in_ready === 1'b1) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL ready_timeout: in_ready still %b after 200 cycles, expected 1", bus.in_ready);
    endtask

    // Offer one character and log outputs for cycles 0..63.
    task automatic capture(input logic [7:0] ch);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_char  = ch;
        log_q[0] = sample();
        for (int k = 1; k < 64; k++) begin
            @(negedge clk);
            if (k == 1) bus.in_valid = 1'b0;
            log_q[k] = sample();
        end
    endtask

    // Hard stop if something hangs far beyond the expected run length.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_char  = 8'h00;
        bus.abort    = 1'b0;

        // Expected outputs per character, hand-derived from unit timing.
        add("E", 1,  8'hFF, 1, 0, 0, 0);
        add("E", 4,  8'hFF, 1, 0, 0, 0);
        add("E", 5,  8'h00, 1, 0, 0, 0);
        add("E", 15, 8'h00, 1, 0, 0, 0);
        add("E", 16, 8'h00, 1, 1, 0, 0);
        add("E", 17, 8'h00, 0, 0, 1, 0);

        add("a", 4,  8'hFF, 1, 0, 0, 0);
        add("a", 5,  8'h00, 1, 0, 0, 0);
        add("a", 8,  8'h00, 1, 0, 0, 0);
        add("a", 9,  8'hFF, 1, 0, 0, 0);
        add("a", 20, 8'hFF, 1, 0, 0, 0);
        add("a", 21, 8'h00, 1, 0, 0, 0);
        add("a", 31, 8'h00, 1, 0, 0, 0);
        add("a", 32, 8'h00, 1, 1, 0, 0);
        add("a", 33, 8'h00, 0, 0, 1, 0);

        add(" ", 1,  8'h00, 1, 0, 0, 0);
        add(" ", 15, 8'h00, 1, 0, 0, 0);
        add(" ", 16, 8'h00, 1, 1, 0, 0);
        add(" ", 17, 8'h00, 0, 0, 1, 0);

        add("#", 1,  8'h00, 0, 0, 0, 1);
        add("#", 2,  8'h00, 0, 0, 1, 0);
        add("{", 1,  8'h00, 0, 0, 0, 1);

        add("Z", 12, 8'hFF, 1, 0, 0, 0);
        add("Z", 13, 8'h00, 1, 0, 0, 0);
        add("Z", 17, 8'hFF, 1, 0, 0, 0);
        add("Z", 28, 8'hFF, 1, 0, 0, 0);
        add("Z", 29, 8'h00, 1, 0, 0, 0);
        add("Z", 33, 8'hFF, 1, 0, 0, 0);
        add("Z", 37, 8'h00, 1, 0, 0, 0);
        add("Z", 41, 8'hFF, 1, 0, 0, 0);
        add("Z", 45, 8'h00, 1, 0, 0, 0);
        add("Z", 56, 8'h00, 1, 1, 0, 0);
        add("Z", 57, 8'h00, 0, 0, 1, 0);

`ifdef MORSE_DIGITS_EN
        add("5", 1,  8'hFF, 1, 0, 0, 0);
        add("5", 5,  8'h00, 1, 0, 0, 0);
        add("5", 9,  8'hFF, 1, 0, 0, 0);
        add("5", 13, 8'h00, 1, 0, 0, 0);
        add("5", 25, 8'hFF, 1, 0, 0, 0);
        add("5", 36, 8'hFF, 1, 0, 0, 0);
        add("5", 37, 8'h00, 1, 0, 0, 0);
        add("5", 48, 8'h00, 1, 1, 0, 0);
        add("5", 49, 8'h00, 0, 0, 1, 0);
`else
        add("5", 1,  8'h00, 0, 0, 0, 1);
        add("5", 2,  8'h00, 0, 0, 1, 0);
`endif

        // Reset state.
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state", sample(), o(8'h00, 0, 0, 0, 0));
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", sample(), o(8'h00, 0, 0, 1, 0));

        // Table-driven character scenarios.
        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 0 || vecs[i].ch != vecs[i-1].ch) capture(vecs[i].ch);
            check($sformatf("char_%c_cyc%0d", vecs[i].ch, vecs[i].cyc),
                  log_q[vecs[i].cyc], vecs[i].exp);
        end

        // Abort 'M' at cycle 6, then 'T' right away.
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_char  = "M";
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) bus.in_valid = 1'b0;
        end
        check("abort_pre", sample(), o(8'hFF, 1, 0, 0, 0));
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_idle", sample(), o(8'h00, 0, 0, 1, 0));
        bus.in_valid = 1'b1;
        bus.in_char  = "T";
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("after_abort_mark", sample(), o(8'hFF, 1, 0, 0, 0));
        // T: dash cycles 8..19, character gap 20..31, done at 31.
        for (int k = 9; k <= 31; k++) @(negedge clk);
        check("after_abort_done", sample(), o(8'h00, 1, 1, 0, 0));
        @(negedge clk);
        check("after_abort_idle", sample(), o(8'h00, 0, 0, 1, 0));

        // Abort in IDLE does nothing.
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_in_idle", sample(), o(8'h00, 0, 0, 1, 0));

        // Abort coinciding with a transfer: the transfer wins.
        bus.abort    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_char  = "E";
        @(negedge clk);
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        check("abort_vs_transfer", sample(), o(8'hFF, 1, 0, 0, 0));
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_in_mark", sample(), o(8'h00, 0, 0, 1, 0));

        // Reset at cycle 10 of 'O'.
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_char  = "O";
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) bus.in_valid = 1'b0;
        end
        check("rst_pre", sample(), o(8'hFF, 1, 0, 0, 0));
        rst = 1'b1;
        #1;
        check("rst_mid_char", sample(), o(8'h00, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;

        // 'E' after reset reproduces the first scenario.
        capture("E");
        check("post_rst_E_cyc1",  log_q[1],  o(8'hFF, 1, 0, 0, 0));
        check("post_rst_E_cyc5",  log_q[5],  o(8'h00, 1, 0, 0, 0));
        check("post_rst_E_cyc16", log_q[16], o(8'h00, 1, 1, 0, 0));
        check("post_rst_E_cyc17", log_q[17], o(8'h00, 0, 0, 1, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
